// File: rtl/tanh_preact_acc_quant_4bit_pkg.sv
// Shared 4-bit activation-code definitions for the tanh/sigmoid stages.
// Saturation helper clamps a wide signed value into the code range.
package tanh_preact_acc_quant_4bit_pkg;

  localparam int ACT_CODE_W   = 4;
  localparam int ACT_CODE_MIN = -8;
  localparam int ACT_CODE_MAX = 7;

  typedef logic signed [ACT_CODE_W-1:0] act_code_t;

  function automatic act_code_t sat_signed(input logic signed [31:0] v);
    act_code_t r;
    if (v < ACT_CODE_MIN) begin
      r = act_code_t'(ACT_CODE_MIN);
    end else if (v > ACT_CODE_MAX) begin
      r = act_code_t'(ACT_CODE_MAX);
    end else begin
      r = v[ACT_CODE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tanh_preact_acc_quant_4bit_if.sv
// Operand stream in, quantized pre-activation stream out, both valid/ready.
interface tanh_preact_acc_quant_4bit_if
  import tanh_preact_acc_quant_4bit_pkg::*;
#(
  parameter int IN_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_x;
  logic signed [IN_W-1:0] in_w;
  logic                   out_valid;
  logic                   out_ready;
  act_code_t              out_code;
  logic                   out_sat;

  modport master (
    output in_valid, in_x, in_w, out_ready,
    input  in_ready, out_valid, out_code, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_w, out_ready,
    output in_ready, out_valid, out_code, out_sat
  );
endinterface

// File: rtl/tanh_preact_acc_quant_4bit_act_sat_shift.sv
// Floor-divide a signed sum by 2**SHIFT, then clamp to the 4-bit code range.
module act_sat_shift
  import tanh_preact_acc_quant_4bit_pkg::*;
#(
  parameter int W     = 12,
  parameter int SHIFT = 2
) (
  input  logic signed [W-1:0] i_sum,
  output act_code_t           o_code,
  output logic                o_sat
);
  logic signed [W-1:0]  w_q;
  logic signed [31:0]   w_q32;

  assign w_q    = i_sum >>> SHIFT;
  assign w_q32  = {{(32-W){w_q[W-1]}}, w_q};
  assign o_code = sat_signed(w_q32);
  assign o_sat  = (w_q32 < ACT_CODE_MIN) || (w_q32 > ACT_CODE_MAX);
endmodule

// File: rtl/tanh_preact_acc_quant_4bit.sv
// Dot-product accumulator feeding the 4-bit tanh stage: LEN signed products per frame,
// shifted and saturated into a registered output code.
module tanh_preact_acc_quant_4bit
  import tanh_preact_acc_quant_4bit_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = 12,
  parameter int SHIFT = 2,
  parameter int OUT_W = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  tanh_preact_acc_quant_4bit_if.slave  io_bus
);
  localparam int CNT_W = $clog2(LEN);

  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_valid;
  logic signed [OUT_W-1:0]  r_code;
  logic                     r_sat;

  logic signed [2*IN_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_last;
  logic                     w_in_ready;
  logic                     w_fire;
  act_code_t                w_code;
  logic                     w_sat;

  assign w_prod = io_bus.in_x * io_bus.in_w;
  assign w_sum  = r_acc + {{(ACC_W-2*IN_W){w_prod[2*IN_W-1]}}, w_prod};
  assign w_last = (r_cnt == CNT_W'(LEN-1));

  // The last beat may only stall while the result register is full and not draining.
  assign w_in_ready = i_rst_n & ~i_clr & ~(w_last & r_valid & ~io_bus.out_ready);
  assign w_fire     = io_bus.in_valid & w_in_ready;

  act_sat_shift #(
    .W     (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .i_sum  (w_sum),
    .o_code (w_code),
    .o_sat  (w_sat)
  );

  // Frame accumulator and beat counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  // Output stage register; a new result may load in the same cycle the old one drains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_sat   <= 1'b0;
    end else if (w_fire && w_last) begin
      r_valid <= 1'b1;
      r_code  <= w_code;
      r_sat   <= w_sat;
    end else if (r_valid && io_bus.out_ready) begin
      r_valid <= 1'b0;
      r_code  <= r_code;
      r_sat   <= r_sat;
    end else begin
      r_valid <= r_valid;
      r_code  <= r_code;
      r_sat   <= r_sat;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_valid;
  assign io_bus.out_code  = r_code;
  assign io_bus.out_sat   = r_sat;
endmodule

// File: tb/tb_tanh_preact_acc_quant_4bit.sv
// Scoreboard bench: expected codes are queued when a frame's last beat is accepted
// and compared when the output handshake completes.
module tb_tanh_preact_acc_quant_4bit;
  import tanh_preact_acc_quant_4bit_pkg::*;

  localparam int LEN   = 8;
  localparam int SHIFT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_code_q[$];
  int exp_sat_q[$];
  int m_sum = 0;
  int m_cnt = 0;

  tanh_preact_acc_quant_4bit_if bus_if ();

  tanh_preact_acc_quant_4bit #(
    .IN_W  (4),
    .LEN   (LEN),
    .ACC_W (12),
    .SHIFT (SHIFT),
    .OUT_W (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (clr),
    .io_bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_accept(input int x, input int w);
    int q;
    m_sum += x * w;
    m_cnt++;
    if (m_cnt == LEN) begin
      q = m_sum >>> SHIFT;
      exp_code_q.push_back((q < -8) ? -8 : ((q > 7) ? 7 : q));
      exp_sat_q.push_back((q < -8 || q > 7) ? 1 : 0);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic beat(input int x, input int w);
    int waited;
    waited = 0;
    @(negedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = 4'(x);
    bus_if.in_w     = 4'(w);
    #3;
    while (!bus_if.in_ready && waited < 50) begin
      @(negedge clk); #4;
      waited++;
    end
    if (!bus_if.in_ready) chk("beat_timeout", int'(bus_if.in_ready), 1);
    else model_accept(x, w);
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    @(negedge clk); #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = ordy;
  endtask

  // Output monitor: samples just before the rising edge, when all inputs are settled.
  always begin
    @(negedge clk); #4;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_code_q.size() == 0) begin
        chk("sb_unexpected", exp_code_q.size(), 1);
      end else begin
        chk("out_code", int'(bus_if.out_code), exp_code_q.pop_front());
        chk("out_sat", int'(bus_if.out_sat), exp_sat_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_x      = 4'sd0;
    bus_if.in_w      = 4'sd0;
    bus_if.out_ready = 1'b0;
    #1;
    chk("rst_valid", int'(bus_if.out_valid), 0);
    chk("rst_code", int'(bus_if.out_code), 0);
    chk("rst_sat", int'(bus_if.out_sat), 0);
    chk("rst_in_ready", int'(bus_if.in_ready), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;

    for (int i = 0; i < 7; i++) beat(1, 1);
    #1 chk("pre_valid", int'(bus_if.out_valid), 0);
    beat(1, 1);
    #1 chk("latency", int'(bus_if.out_valid), 1);

    for (int i = 0; i < 8; i++) beat(7, 7);
    for (int i = 0; i < 8; i++) beat(-8, 7);
    for (int i = 0; i < 8; i++) beat(-8, -8);
    beat(-1, 1);
    for (int i = 0; i < 7; i++) beat(0, 0);
    idle(1'b1);
    repeat (3) @(negedge clk);

    // Backpressure: frame 2's last beat waits for the held frame 1 result.
    idle(1'b0);
    for (int i = 0; i < 8; i++) beat(-1, 1);
    for (int i = 0; i < 7; i++) beat(3, 1);
    @(negedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = 4'sd3;
    bus_if.in_w     = 4'sd1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_rdy", int'(bus_if.in_ready), 0);
      chk("held_valid", int'(bus_if.out_valid), 1);
      @(negedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    #3;
    chk("handoff_rdy", int'(bus_if.in_ready), 1);
    if (bus_if.in_ready) model_accept(3, 1);
    @(posedge clk); #1;
    chk("handoff_valid", int'(bus_if.out_valid), 1);
    idle(1'b1);
    repeat (3) @(negedge clk);

    // Flush a partial frame with clr while a beat is offered.
    for (int i = 0; i < 3; i++) beat(7, 7);
    @(negedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = 4'sd7;
    bus_if.in_w     = 4'sd7;
    clr = 1'b1;
    #3;
    chk("clr_rdy", int'(bus_if.in_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    bus_if.in_valid = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    for (int i = 0; i < 8; i++) beat(1, 1);
    idle(1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-frame with a result pending.
    idle(1'b0);
    for (int i = 0; i < 8; i++) beat(1, 1);
    for (int i = 0; i < 3; i++) beat(7, 7);
    @(negedge clk); #1;
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", int'(bus_if.out_valid), 0);
    chk("rst2_code", int'(bus_if.out_code), 0);
    chk("rst2_in_ready", int'(bus_if.in_ready), 0);
    exp_code_q.delete();
    exp_sat_q.delete();
    m_sum = 0;
    m_cnt = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) beat(1, 1);
    idle(1'b1);
    repeat (5) @(negedge clk);
    chk("sb_drain", exp_code_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
